// File: rtl/mdu_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_param : parametrised multi-cycle multiply/divide unit holding HI/LO.   |
// | Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10).       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module mdu_param #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] C_MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] C_DIV_N  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

   localparam logic [3:0] C_OP_MULT  = 4'd1;
   localparam logic [3:0] C_OP_MULTU = 4'd2;
   localparam logic [3:0] C_OP_DIV   = 4'd3;
   localparam logic [3:0] C_OP_DIVU  = 4'd4;
   localparam logic [3:0] C_OP_MTHI  = 4'd5;
   localparam logic [3:0] C_OP_MTLO  = 4'd6;
   localparam logic [3:0] C_OP_MADD  = 4'd7;
   localparam logic [3:0] C_OP_MADDU = 4'd8;
   localparam logic [3:0] C_OP_MSUB  = 4'd9;
   localparam logic [3:0] C_OP_MSUBU = 4'd10;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   logic               w_signed, w_is_div, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_div_b, w_q, w_r, w_quo, w_rem;
   logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_res;

   // Datapath works on the latched operands; it has the full busy period to settle.
   always_comb begin
      w_signed = (op_q == C_OP_MULT) || (op_q == C_OP_DIV) ||
                 (op_q == C_OP_MADD) || (op_q == C_OP_MSUB);
      w_is_div = (op_q == C_OP_DIV) || (op_q == C_OP_DIVU);
      w_ext_a  = w_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      w_ext_b  = w_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      w_prod   = w_ext_a * w_ext_b;

      // Sign-magnitude division; MIN / -1 wraps naturally to LO = MIN, HI = 0.
      w_a_neg  = w_signed && a_q[WIDTH-1];
      w_b_neg  = w_signed && b_q[WIDTH-1];
      w_mag_a  = w_a_neg ? -a_q : a_q;
      w_mag_b  = w_b_neg ? -b_q : b_q;
      w_div_b  = (w_mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
      w_q      = w_mag_a / w_div_b;
      w_r      = w_mag_a % w_div_b;
      w_quo    = (w_a_neg ^ w_b_neg) ? -w_q : w_q;
      w_rem    = w_a_neg ? -w_r : w_r;

      w_res = {hi_q, lo_q};
      case (op_q)
         C_OP_MULT, C_OP_MULTU: w_res = w_prod;
         C_OP_DIV,  C_OP_DIVU:  w_res = {w_rem, w_quo};
`ifdef MDU_MADD_EN
         C_OP_MADD, C_OP_MADDU: w_res = {hi_q, lo_q} + w_prod;
         C_OP_MSUB, C_OP_MSUBU: w_res = {hi_q, lo_q} - w_prod;
`endif
         default:               w_res = {hi_q, lo_q};
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               case (op_i)
                  C_OP_MULT, C_OP_MULTU,
`ifdef MDU_MADD_EN
                  C_OP_MADD, C_OP_MADDU, C_OP_MSUB, C_OP_MSUBU,
`endif
                  C_OP_DIV, C_OP_DIVU: begin
                     state_d = S_RUN;
                     cnt_d   = ((op_i == C_OP_DIV) || (op_i == C_OP_DIVU)) ? C_DIV_N : C_MULT_N;
                     op_d    = op_i;
                     a_d     = src_a_i;
                     b_d     = src_b_i;
                  end
                  C_OP_MTHI: hi_d = src_a_i;
                  C_OP_MTLO: lo_d = src_a_i;
                  default:   ;
               endcase
            end
         end
         S_RUN: begin
            if (flush_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q <= C_ONE) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               // A zero divisor still burns the full latency but leaves HI/LO alone.
               if (!(w_is_div && (b_q == '0))) begin
                  hi_d = w_res[2*WIDTH-1:WIDTH];
                  lo_d = w_res[WIDTH-1:0];
               end
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == S_RUN);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdu_param : randomized self-checking bench for mdu_param (defaults).   |
// | Revision     : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_mdu_param;

   logic        clk_i = 1'b0;
   logic        reset_i, start_i, flush_i;
   logic [3:0]  op_i;
   logic [31:0] src_a_i, src_b_i;
   logic        busy_o, done_o;
   logic [31:0] hi_o, lo_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk_i = ~clk_i;

   mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (start_i),
      .op_i    (op_i),
      .flush_i (flush_i),
      .src_a_i (src_a_i),
      .src_b_i (src_b_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int latency(input int op);
      case (op)
         1, 2:    return 5;
         3, 4:    return 10;
`ifdef MDU_MADD_EN
         7, 8, 9, 10: return 5;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 output logic [31:0] hi_out, output logic [31:0] lo_out);
      longint          sa  = longint'($signed(a));
      longint          sb  = longint'($signed(b));
      longint unsigned ua  = 64'(a);
      longint unsigned ub  = 64'(b);
      longint unsigned acc = {hi_in, lo_in};
      longint unsigned res;
      int              ia  = $signed(a);
      int              ib  = $signed(b);
      hi_out = hi_in;
      lo_out = lo_in;
      case (op)
         1: begin res = longint'(sa * sb); {hi_out, lo_out} = res; end
         2: begin res = ua * ub;           {hi_out, lo_out} = res; end
         3: if (b != 0) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  lo_out = 32'h8000_0000;
                  hi_out = 32'h0;
               end else begin
                  lo_out = ia / ib;
                  hi_out = ia % ib;
               end
            end
         4: if (b != 0) begin
               lo_out = a / b;
               hi_out = a % b;
            end
         5: hi_out = a;
         6: lo_out = a;
`ifdef MDU_MADD_EN
         7:  begin res = acc + longint'(sa * sb); {hi_out, lo_out} = res; end
         8:  begin res = acc + ua * ub;           {hi_out, lo_out} = res; end
         9:  begin res = acc - longint'(sa * sb); {hi_out, lo_out} = res; end
         10: begin res = acc - ua * ub;           {hi_out, lo_out} = res; end
`endif
         default: ;
      endcase
   endfunction

   // Issue one op in the current cycle and follow it to completion; optionally poke
   // a start during busy cycle poke_k, which must be ignored.
   task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_k, input int poke_op);
      int          n;
      logic [31:0] eh, el;
      n = latency(op);
      model(op, a, b, m_hi, m_lo, eh, el);
      start_i = 1'b1; op_i = 4'(op); src_a_i = a; src_b_i = b;
      step();
      start_i = 1'b0; src_a_i = $urandom; src_b_i = $urandom;
      if (n == 0) begin
         check("nobusy", busy_o, 1'b0);
         check("nodone", done_o, 1'b0);
      end else begin
         for (int k = 1; k <= n; k++) begin
            check("busy", busy_o, 1'b1);
            check("done_low", done_o, 1'b0);
            check("hi_hold", hi_o, m_hi);
            check("lo_hold", lo_o, m_lo);
            if (k == poke_k) begin
               start_i = 1'b1; op_i = 4'(poke_op);
            end
            step();
            start_i = 1'b0;
         end
         check("busy_end", busy_o, 1'b0);
         check("done", done_o, 1'b1);
      end
      check("hi", hi_o, eh);
      check("lo", lo_o, el);
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      int op;
      logic [31:0] a, b;
      reset_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
      src_a_i = '0; src_b_i = '0;
      step();
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_hi", hi_o, 32'h0);
      check("rst_lo", lo_o, 32'h0);
      reset_i = 1'b0;
      step();

      do_op(1, 32'hFFFF_FFFD, 32'd7, 0, 0);
      check("mult_hi_k", hi_o, 32'hFFFF_FFFF);
      check("mult_lo_k", lo_o, 32'hFFFF_FFEB);
      step();
      check("done_pulse", done_o, 1'b0);

      do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_hi_k", hi_o, 32'hFFFF_FFFE);
      check("multu_lo_k", lo_o, 32'h0000_0001);
      do_op(3, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_lo_k", lo_o, 32'hFFFF_FFFD);
      check("div_hi_k", hi_o, 32'hFFFF_FFFF);

      do_op(5, 32'h11, 32'h0, 0, 0);
      do_op(6, 32'h22, 32'h0, 0, 0);
      do_op(4, 32'd7, 32'd0, 0, 0);
      check("div0_hi_k", hi_o, 32'h11);
      check("div0_lo_k", lo_o, 32'h22);

      // Flush raised during cycle T+3 of a MULT.
      start_i = 1'b1; op_i = 4'd1; src_a_i = 32'd9; src_b_i = 32'd9;
      step();
      start_i = 1'b0;
      step();
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
         check("flush_busy", busy_o, 1'b0);
         check("flush_done", done_o, 1'b0);
         check("flush_hi", hi_o, m_hi);
         check("flush_lo", lo_o, m_lo);
         step();
      end

      // Flush in IDLE blocks a same-cycle start.
      start_i = 1'b1; op_i = 4'd5; flush_i = 1'b1; src_a_i = 32'hDEAD_BEEF;
      step();
      check("fl_mthi_hi", hi_o, m_hi);
      op_i = 4'd1;
      step();
      start_i = 1'b0; flush_i = 1'b0;
      check("fl_start_busy", busy_o, 1'b0);

      do_op(5, 32'h1234_5678, 32'h0, 0, 0);
      check("mthi_k", hi_o, 32'h1234_5678);
      do_op(1, 32'd1000, 32'hFFFF_FFFE, 2, 1);
      do_op(3, 32'd100, 32'd7, 3, 5);
      do_op(4, 32'd100, 32'd7, 9, 6);
      do_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      do_op(3, 32'h8000_0005, 32'd3, 0, 0);

`ifdef MDU_MADD_EN
      do_op(6, 32'd5, 32'h0, 0, 0);
      do_op(5, 32'd0, 32'h0, 0, 0);
      do_op(7, 32'd2, 32'd3, 0, 0);
      check("madd_lo_k", lo_o, 32'd11);
      check("madd_hi_k", hi_o, 32'd0);
`else
      do_op(7, 32'd2, 32'd3, 0, 0);
      do_op(10, 32'd2, 32'd3, 0, 0);
`endif

      for (int i = 0; i < 80; i++) begin
         op = int'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'h0;
         if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         do_op(op, a, b, int'($urandom_range(0, 4)), int'($urandom_range(1, 6)));
      end

      // Asynchronous reset in the middle of a DIV.
      do_op(5, 32'hAAAA_5555, 32'h0, 0, 0);
      start_i = 1'b1; op_i = 4'd3; src_a_i = 32'd77; src_b_i = 32'd5;
      step();
      start_i = 1'b0;
      step();
      step();
      check("pre_rst_busy", busy_o, 1'b1);
      #2 reset_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 1'b0);
      check("arst_done", done_o, 1'b0);
      check("arst_hi", hi_o, 32'h0);
      check("arst_lo", lo_o, 32'h0);
      step();
      reset_i = 1'b0;
      m_hi = '0;
      m_lo = '0;
      step();
      check("post_rst_busy", busy_o, 1'b0);
      do_op(2, 32'd6, 32'd7, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_param.md
# mdu_param

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It succeeds the fixed 32-bit MDU and adds:
- configurable operand width and separate multiply/divide latencies;
- a flush input that cancels an in-flight operation on pipeline cancellation;
- a one-cycle `done` pulse;
- defined divide-by-zero behaviour.

HI/LO are held internally and read by the E stage for `mfhi`/`mflo`. Hazard logic stalls D-stage MDU instructions while `busy | start`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; even, ≥ 8.
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (and MADD family); ≥ 1.
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU; ≥ 1.

- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: operation request, sampled with `op`.
- `op` input 4: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7–10 MADD/MADDU/MSUB/MSUBU (see Configuration); other codes NOP.
- `flush` input 1: cancel the in-flight operation and block a same-cycle start.
- `src_a` input WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `src_b` input WIDTH: rt operand.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when a result commits.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **States:** IDLE, RUN. The down-counter is sized to max(MULT_CYCLES, DIV_CYCLES).
- **IDLE, `start` = 1, `flush` = 0:**
  - op 1–4 (7–10 if enabled): latch operands and op, load counter with N, go to RUN.
  - op 5: HI ← `src_a` at the next edge; stay in IDLE.
  - op 6: LO ← `src_a` at the next edge; stay in IDLE.
  - op 0 or undefined codes: no effect.
- **RUN:**
  - Counter decrements each cycle.
  - On the edge where the counter reaches 0, commit HI/LO, go to IDLE, and set `done` for the following cycle.
- **Arithmetic:**
  - MULT/MULTU: {HI, LO} ← 2·WIDTH-bit signed/unsigned product.
  - DIV/DIVU: LO ← quotient truncated toward zero; HI ← remainder, carrying the sign of the dividend.
  - Signed MIN / −1: LO = MIN, HI = 0.
  - Divisor 0: full DIV_CYCLES busy, `done` pulses, HI and LO unchanged.
- **`start` while RUN:** ignored, including MTHI/MTLO. The caller guarantees a stall.
- **`flush` in RUN:** next edge → IDLE; pending result discarded; HI/LO unchanged; no `done`.
- **`flush` with `start` in IDLE:** start ignored.
- **`flush` on the commit edge:** flush wins; no commit.
- **Reset:** asynchronous; immediately forces IDLE, counter 0, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, regardless of state.

## Timing
- `start` is sampled at edge E0 (end of cycle T).
- `busy` = 1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- In cycle T+N+1: `busy` = 0, `done` = 1, and the new `hi`/`lo` are visible.
- `hi`/`lo` are registered and hold their old values throughout `busy`.
- MTHI/MTLO: the value is visible in cycle T+1; `busy` and `done` stay 0.
- A new `start` is accepted in the cycle where `done` = 1 (back-to-back operation).
- `busy` and `done` are never 1 in the same cycle.

## Configuration
- Macro: `MDU_MADD_EN`.
- **Defined:** ops 7–10 are supported, with MULT_CYCLES latency:
  - MADD/MADDU: {HI, LO} ← {HI, LO} + signed/unsigned product, modulo 2^(2·WIDTH).
  - MSUB/MSUBU: {HI, LO} ← {HI, LO} − signed/unsigned product, modulo 2^(2·WIDTH).
  - Accumulation uses the HI/LO values present at the commit edge.
- **Not defined:** ops 7–10 decode as NOP: no `busy`, HI/LO unchanged.

## Test plan
Default parameters for all scenarios.
- **MULT:** `src_a` = 0xFFFFFFFD, `src_b` = 7 → `busy` for 5 cycles; then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, `done` = 1 for one cycle.
- **MULTU then DIV back-to-back:**
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
  - DIV issued in the `done` cycle, −7 / 2 → after 10 busy cycles, `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- **DIVU by zero:** `hi` = 0x11, `lo` = 0x22, DIVU 7 / 0 → 10 busy cycles, `done` pulses, `hi`/`lo` stay 0x11/0x22.
- **Flush mid-multiply:** `flush` in cycle T+3 of a MULT → `busy` = 0 from T+4, `hi`/`lo` unchanged, `done` never asserted.
- **MTHI and start-while-busy:**
  - MTHI 0x12345678 while idle → `hi` = 0x12345678 in the next cycle, `busy` stays 0.
  - MULT `start` while `busy` → ignored; original result unaffected.
- **Reset and MADD:**
  - `reset` asserted mid-DIV → `busy`, `hi`, `lo` = 0 immediately.
  - With `MDU_MADD_EN` defined, `lo` = 5, MADD 2 × 3 → `lo` = 11, `hi` = 0.
